multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/rvx10_ctrl_pkg.sv | 40 ++++
 rtl/ctrl_outdec.sv | 97 +++++++++
 rtl/multicycle_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/rvx10_ctrl_pkg.sv
// rvx10_ctrl_pkg: state, opcode and datapath-select encodings for the multicycle controller
package rvx10_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        TRAP     = 4'd12
    } state_t;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_RTYPE   = 7'b0110011;
    localparam logic [6:0] OP_ITYPE   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_RFN  = 2'b10;
    localparam logic [1:0] ALUOP_IFN  = 2'b11;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
endpackage

// File: rtl/ctrl_outdec.sv
// ctrl_outdec: Moore decode of controller state into datapath strobes and selects
module ctrl_outdec
    import rvx10_ctrl_pkg::*;
(
    input  logic       i_run,
    input  state_t     i_state,
    input  logic       i_rdy,
    input  logic [6:0] i_op,
    output logic       o_mem_req,
    output logic       o_pcupdate,
    output logic       o_branch,
    output logic       o_adrsrc,
    output logic       o_irwrite,
    output logic       o_memwrite,
    output logic       o_regwrite,
    output logic [1:0] o_resultsrc,
    output logic [1:0] o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_aluop,
    output logic       o_custom,
    output logic       o_illegal
);
    // i_run low (reset held) suppresses every output, so FETCH decodes cannot leak out
    always_comb begin
        o_mem_req   = 1'b0;
        o_pcupdate  = 1'b0;
        o_branch    = 1'b0;
        o_adrsrc    = 1'b0;
        o_irwrite   = 1'b0;
        o_memwrite  = 1'b0;
        o_regwrite  = 1'b0;
        o_resultsrc = RES_ALUOUT;
        o_alusrca   = SRCA_PC;
        o_alusrcb   = SRCB_RS2;
        o_aluop     = ALUOP_ADD;
        o_custom    = 1'b0;
        o_illegal   = 1'b0;
        if (i_run)
            case (i_state)
                FETCH: begin
                    o_mem_req   = 1'b1;
                    o_alusrcb   = SRCB_FOUR;
                    o_resultsrc = RES_ALURES;
                    o_irwrite   = i_rdy;
                    o_pcupdate  = i_rdy;
                end
                DECODE: begin
                    o_alusrca = SRCA_OLDPC;
                    o_alusrcb = SRCB_IMM;
                end
                MEMADR: begin
                    o_alusrca = SRCA_RS1;
                    o_alusrcb = SRCB_IMM;
                end
                MEMREAD: begin
                    o_mem_req = 1'b1;
                    o_adrsrc  = 1'b1;
                end
                MEMWB: begin
                    o_resultsrc = RES_DATA;
                    o_regwrite  = 1'b1;
                end
                MEMWRITE: begin
                    o_mem_req  = 1'b1;
                    o_adrsrc   = 1'b1;
                    o_memwrite = i_rdy;
                end
                EXECR: begin
                    o_alusrca = SRCA_RS1;
                    o_aluop   = ALUOP_RFN;
                    o_custom  = i_op == OP_CUSTOM0;
                end
                EXECI: begin
                    o_alusrca = SRCA_RS1;
                    o_alusrcb = SRCB_IMM;
                    o_aluop   = ALUOP_IFN;
                end
                ALUWB: o_regwrite = 1'b1;
                BEQ: begin
                    o_alusrca = SRCA_RS1;
                    o_aluop   = ALUOP_SUB;
                    o_branch  = 1'b1;
                end
                JAL: begin
                    o_alusrca  = SRCA_OLDPC;
                    o_alusrcb  = SRCB_FOUR;
                    o_pcupdate = 1'b1;
                end
                LUI: begin
                    o_alusrca = SRCA_ZERO;
                    o_alusrcb = SRCB_IMM;
                end
                TRAP: o_illegal = 1'b1;
                default: ;
            endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32 control FSM with optional RVX10 custom op and memory handshake
module multicycle_ctrl
    import rvx10_ctrl_pkg::*;
#(
    parameter bit RVX10_EN = 1'b1,
    parameter bit MEM_HS   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pcupdate,
    output logic       branch,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       custom,
    output logic       illegal,
    output logic [3:0] state_o
);
    state_t r_state;
    state_t w_next;
    logic   w_rdy;
    assign w_rdy   = MEM_HS ? mem_ready : 1'b1;
    assign state_o = r_state;
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= FETCH;
        else        r_state <= w_next;
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:    w_next = w_rdy ? DECODE : FETCH;
            DECODE:
                case (op)
                    OP_LOAD, OP_STORE: w_next = MEMADR;
                    OP_RTYPE:          w_next = EXECR;
                    OP_ITYPE:          w_next = EXECI;
                    OP_BRANCH:         w_next = BEQ;
                    OP_JAL:            w_next = JAL;
                    OP_LUI:            w_next = LUI;
                    OP_CUSTOM0:        w_next = RVX10_EN ? EXECR : TRAP;
                    default:           w_next = TRAP;
                endcase
            MEMADR:   w_next = op == OP_LOAD ? MEMREAD : MEMWRITE;
            MEMREAD:  w_next = w_rdy ? MEMWB : MEMREAD;
            MEMWRITE: w_next = w_rdy ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL, LUI: w_next = ALUWB;
            TRAP:     w_next = TRAP;
            default:  w_next = FETCH;
        endcase
    end
    ctrl_outdec u_outdec (
        .i_run       (reset),
        .i_state     (r_state),
        .i_rdy       (w_rdy),
        .i_op        (op),
        .o_mem_req   (mem_req),
        .o_pcupdate  (pcupdate),
        .o_branch    (branch),
        .o_adrsrc    (adrsrc),
        .o_irwrite   (irwrite),
        .o_memwrite  (memwrite),
        .o_regwrite  (regwrite),
        .o_resultsrc (resultsrc),
        .o_alusrca   (alusrca),
        .o_alusrcb   (alusrcb),
        .o_aluop     (aluop),
        .o_custom    (custom),
        .o_illegal   (illegal)
    );
endmodule
